// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: walks a flat byte ROM, buffers {pc, instr} pairs in a FIFO for decode.
// Optional macro FETCH_PERF_CNT_EN adds a saturating stall_cycles counter output.
module fetch_queue_unit #(
    parameter int unsigned ROM_BYTES   = 1024,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ROM_BYTES*8-1:0]         instr_rom,
    input  logic [31:0]                    rom_size,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           fetch_complete
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int unsigned ADDR_W = $clog2(ROM_BYTES);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(QUEUE_DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fetch_complete_q, fetch_complete_d;

    logic [31:0] pc_mem    [QUEUE_DEPTH];
    logic [31:0] instr_mem [QUEUE_DEPTH];

    logic [32:0]       limit;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       fetch_word;
    logic              at_end;
    logic              pop;
    logic              push;
    logic              mem_we;
    logic [1:0]        unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Unsigned 33-bit compare so a pc near 2^32 cannot wrap back into range.
    function automatic logic past_limit(input logic [31:0] pc, input logic [32:0] lim);
        return ({1'b0, pc} + 33'd4) > lim;
    endfunction

    always_comb begin
        limit = {1'b0, rom_size};
        if (rom_size > 32'(ROM_BYTES)) begin
            limit = 33'(ROM_BYTES);
        end
    end

    // Little-endian: the byte at fetch_pc lands in bits [7:0] of the word.
    assign rom_addr   = fetch_pc_q[ADDR_W-1:0];
    assign fetch_word = instr_rom[{rom_addr, 3'b000} +: 32];

    assign out_valid  = (count_q != '0);
    assign at_end     = past_limit(fetch_pc_q, limit);
    assign pop        = out_valid && out_ready;
    assign push       = (state_q == ST_RUN) && !at_end && ((count_q < FULL_COUNT) || pop);
    assign mem_we     = push && !redirect_valid;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            state_d    = past_limit(fetch_pc_d, limit) ? ST_DONE : ST_RUN;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (state_q == ST_RUN) begin
                if (at_end || (push && past_limit(fetch_pc_d, limit))) begin
                    state_d = ST_DONE;
                end
            end
        end
        fetch_complete_d = (state_d == ST_DONE) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            fetch_pc_q       <= RESET_PC;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            fetch_complete_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            fetch_complete_q <= fetch_complete_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (mem_we) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= fetch_word;
        end
    end

    assign out_pc         = pc_mem[rd_ptr_q];
    assign out_instr      = instr_mem[rd_ptr_q];
    assign queue_count    = count_q;
    assign fetch_complete = fetch_complete_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else if (out_valid && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
